// File: rtl/uart_pkg.sv
// uart_pkg: shared parity modes, receive FSM encoding and sizing helper for the UART receiver
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} rx_state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: serial line, FIFO drain handshake and status of the UART receiver
interface uart_rx_fifo_if #(parameter int DATA_BITS = 8);
  logic                 rx;
  logic                 out_ready;
  logic                 out_valid;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_perr;
  logic                 out_ferr;
  logic                 overrun;
  logic                 ovr_clr;
  logic                 busy;
  modport master (output rx, out_ready, ovr_clr,
                  input  out_valid, out_data, out_perr, out_ferr, overrun, busy);
  modport slave  (input  rx, out_ready, ovr_clr,
                  output out_valid, out_data, out_perr, out_ferr, overrun, busy);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; head entry is always visible on rdata_o
module sync_fifo import uart_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);
  localparam int AW = clog2(DEPTH);
  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;
  assign empty_o = wptr_q == rptr_q;
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // a pop in the same cycle frees the slot the push lands in
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: majority-sampled UART receiver pushing {perr, ferr, data} words into a FWFT FIFO
module uart_rx_fifo import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input logic           clock,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = clog2(CLKS_PER_BIT);
  localparam int BW   = clog2(DATA_BITS);
  rx_state_e            state_q, state_d;
  logic                 s1_q, s2_q, prev_q, m0_q, m1_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 fall, maj, decide, eob, push, pop, full, empty;
  logic [DATA_BITS+1:0] wdata, rdata;
  assign fall   = prev_q && !s2_q;
  assign maj    = (m0_q & m1_q) | (m0_q & s2_q) | (m1_q & s2_q);
  assign decide = cnt_q == CW'(HALF + 1);
  assign eob    = cnt_q == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        bit_d  = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (fall) state_d = S_START;
      end
      S_START: state_d = (decide && maj) ? S_IDLE : eob ? S_DATA : S_START;
      S_DATA: begin
        if (decide) sh_d = {maj, sh_q[DATA_BITS-1:1]};
        if (eob) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(DATA_BITS - 1)) state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP1;
        end
      end
      S_PARITY: begin
        if (decide) perr_d = maj != (^sh_q ^ (PARITY == PAR_ODD));
        if (eob) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (decide) begin
          ferr_d = !maj;
          // single stop bit: leave early so a back-to-back start edge is not missed
          if (STOP_BITS == 1) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end else if (eob) state_d = S_STOP2;
      end
      S_STOP2: begin
        if (decide) begin
          ferr_d  = ferr_q | !maj;
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_q == S_IDLE || state_d == S_IDLE || eob) ? '0 : cnt_q + 1'b1;
  end
  assign wdata = {perr_q, ferr_d, sh_q};
  assign pop   = bus.out_valid && bus.out_ready;
  assign ovr_d = (push && full && !pop) || (ovr_q && !bus.ovr_clr);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      m0_q    <= 1'b1;
      m1_q    <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      s1_q    <= bus.rx;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      m0_q    <= (cnt_q == CW'(HALF - 1)) ? s2_q : m0_q;
      m1_q    <= (cnt_q == CW'(HALF)) ? s2_q : m1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (wdata),
    .full_o  (full),
    .pop_i   (pop),
    .rdata_o (rdata),
    .empty_o (empty)
  );
  assign bus.out_valid = !empty;
  assign {bus.out_perr, bus.out_ferr, bus.out_data} = rdata;
  assign bus.overrun = ovr_q;
  assign bus.busy    = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: 8N1 and 8E2 receivers driven by serial frames, checked against a queue model
module tb_uart_rx_fifo;
  localparam int CPB = 16;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  always #5 clock = ~clock;
  uart_rx_fifo_if #(.DATA_BITS(8)) if0 ();
  uart_rx_fifo_if #(.DATA_BITS(8)) if1 ();
  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clock(clock), .reset(reset), .bus(if0));
  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clock(clock), .reset(reset), .bus(if1));
  typedef struct {
    logic [7:0] d;
    logic       pb;
    logic       st1;
    logic       st2;
    logic [7:0] xd;
    logic       xp;
    logic       xf;
  } vec_t;
  vec_t           tbl [6];
  logic [9:0]     q [$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic logic [11:0] head(input int w);
    return (w == 0) ? {if0.out_valid, if0.out_perr, if0.out_ferr, if0.out_data, if0.busy}
                    : {if1.out_valid, if1.out_perr, if1.out_ferr, if1.out_data, if1.busy};
  endfunction
  task automatic drive(input int w, input logic v);
    if (w == 0) if0.rx = v;
    else if1.rx = v;
  endtask
  task automatic bit_out(input int w, input logic v, input bit spk);
    for (int i = 0; i < CPB; i++) begin
      drive(w, (spk && i == 8) ? 1'b0 : v);
      @(negedge clock);
    end
  endtask
  // frame: start, 8 data LSB first, parity and second stop only on the 8E2 receiver
  task automatic send(input int w, input logic [7:0] d, input logic pb, input logic st1,
                      input logic st2, input int spike);
    bit_out(w, 1'b0, 1'b0);
    for (int b = 0; b < 8; b++) bit_out(w, d[b], spike == b);
    if (w == 1) bit_out(w, pb, 1'b0);
    bit_out(w, st1, 1'b0);
    if (w == 1) bit_out(w, st2, 1'b0);
    drive(w, 1'b1);
  endtask
  task automatic pop_chk(input int w, input string n, input logic [7:0] xd, input logic xp,
                         input logic xf);
    int t;
    logic [11:0] h;
    t = 0;
    while (!head(w)[11] && t < 400) begin
      @(negedge clock);
      t++;
    end
    h = head(w);
    chk($sformatf("%s.valid", n), 32'(h[11]), 32'd1);
    chk($sformatf("%s.data", n), 32'(h[8:1]), 32'(xd));
    chk($sformatf("%s.perr_ferr", n), 32'(h[10:9]), 32'({xp, xf}));
    if (w == 0) if0.out_ready = 1'b1;
    else if1.out_ready = 1'b1;
    @(negedge clock);
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int seen_busy, seen_valid, n;
    logic [7:0] d;
    logic pb, st1, st2;
    logic [9:0] e;
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[1] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1};
    tbl[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    if0.rx = 1'b1; if0.out_ready = 1'b0; if0.ovr_clr = 1'b0;
    if1.rx = 1'b1; if1.out_ready = 1'b0; if1.ovr_clr = 1'b0;
    repeat (3) @(negedge clock);
    for (int w = 0; w < 2; w++) chk($sformatf("reset.head%0d", w), 32'(head(w)), 32'd0);
    chk("reset.overrun", 32'({if0.overrun, if1.overrun}), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    fork
      send(0, 8'h35, 1'b0, 1'b1, 1'b1, -1);
      begin
        repeat (156) @(negedge clock);
        chk("basic.valid_before_push", 32'(if0.out_valid), 32'd0);
        @(negedge clock);
        chk("basic.valid_after_push", 32'(if0.out_valid), 32'd1);
      end
    join
    pop_chk(0, "basic", 8'h35, 1'b0, 1'b0);
    chk("basic.empty", 32'(if0.out_valid), 32'd0);
    if0.rx = 1'b0;
    repeat (3) @(negedge clock);
    if0.rx = 1'b1;
    seen_busy = 0;
    seen_valid = 0;
    repeat (40) begin
      @(negedge clock);
      seen_busy += int'(if0.busy);
      seen_valid += int'(if0.out_valid);
    end
    chk("glitch.busy_pulsed", 32'(seen_busy != 0), 32'd1);
    chk("glitch.no_push", 32'(seen_valid), 32'd0);
    chk("glitch.back_idle", 32'(if0.busy), 32'd0);
    send(0, 8'hFF, 1'b0, 1'b1, 1'b1, 3);
    pop_chk(0, "spike", 8'hFF, 1'b0, 1'b0);
    send(0, 8'h0D, 1'b0, 1'b0, 1'b1, -1);
    repeat (CPB) @(negedge clock);
    pop_chk(0, "ferr", 8'h0D, 1'b0, 1'b1);
    send(0, 8'h31, 1'b0, 1'b1, 1'b1, -1);
    pop_chk(0, "after_ferr", 8'h31, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send(1, tbl[i].d, tbl[i].pb, tbl[i].st1, tbl[i].st2, -1);
      repeat (CPB) @(negedge clock);
      pop_chk(1, $sformatf("tbl%0d", i), tbl[i].xd, tbl[i].xp, tbl[i].xf);
    end
    for (int i = 1; i <= 5; i++) send(0, 8'(i * 17), 1'b0, 1'b1, 1'b1, -1);
    chk("ovr.set", 32'(if0.overrun), 32'd1);
    for (int i = 1; i <= 4; i++) pop_chk(0, $sformatf("ovr_pop%0d", i), 8'(i * 17), 1'b0, 1'b0);
    chk("ovr.drained", 32'(if0.out_valid), 32'd0);
    chk("ovr.sticky", 32'(if0.overrun), 32'd1);
    if0.ovr_clr = 1'b1;
    @(negedge clock);
    if0.ovr_clr = 1'b0;
    chk("ovr.cleared", 32'(if0.overrun), 32'd0);
    for (int i = 1; i <= 4; i++) send(0, 8'(8'hA0 + i), 1'b0, 1'b1, 1'b1, -1);
    fork
      send(0, 8'hA5, 1'b0, 1'b1, 1'b1, -1);
      begin
        repeat (156) @(negedge clock);
        if0.out_ready = 1'b1;
        @(negedge clock);
        if0.out_ready = 1'b0;
      end
    join
    chk("fullpop.no_overrun", 32'(if0.overrun), 32'd0);
    for (int i = 2; i <= 5; i++) pop_chk(0, $sformatf("fullpop%0d", i), 8'(8'hA0 + i), 1'b0, 1'b0);
    chk("fullpop.empty", 32'(if0.out_valid), 32'd0);
    repeat (6) begin
      n = $urandom_range(1, 4);
      repeat (n) begin
        d = 8'($urandom);
        pb = 1'($urandom);
        st1 = $urandom_range(0, 3) != 0;
        st2 = $urandom_range(0, 3) != 0;
        send(1, d, pb, st1, st2, -1);
        if (!(st1 && st2)) repeat (CPB) @(negedge clock);
        q.push_back({pb != (^d), !(st1 && st2), d});
      end
      while (q.size() != 0) begin
        e = q.pop_front();
        pop_chk(1, "rand", e[7:0], e[9], e[8]);
      end
    end
    chk("rand.empty_no_overrun", 32'({if1.out_valid, if1.overrun}), 32'd0);
    send(0, 8'h5A, 1'b0, 1'b1, 1'b1, -1);
    chk("rstmid.pre_valid", 32'(if0.out_valid), 32'd1);
    fork
      send(0, 8'hC3, 1'b0, 1'b1, 1'b1, -1);
      begin
        repeat (60) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rstmid.head", 32'(head(0)), 32'd0);
        chk("rstmid.overrun", 32'(if0.overrun), 32'd0);
      end
    join
    reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("rstmid.still_empty", 32'(head(0)), 32'd0);
    send(0, 8'h96, 1'b0, 1'b1, 1'b1, -1);
    pop_chk(0, "post_reset", 8'h96, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
